// File: rtl/pwm_regs_pkg.sv
// Register map, bit positions and FSM encoding shared by the PWM generator and capture blocks.
package pwm_regs_pkg;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CTRL_W   = 2;
  localparam int unsigned STATUS_W = 4;

  // capture block register addresses
  localparam logic [ADDR_W-1:0] CAP_CTRL_ADDR   = 8'h00;
  localparam logic [ADDR_W-1:0] CAP_STATUS_ADDR = 8'h04;
  localparam logic [ADDR_W-1:0] CAP_HIGH_ADDR   = 8'h08;
  localparam logic [ADDR_W-1:0] CAP_PERIOD_ADDR = 8'h0C;

  // generator register addresses used by top_pwm
  localparam logic [ADDR_W-1:0] TOP_PWM_CTRL_ADDR   = 8'h00;
  localparam logic [ADDR_W-1:0] TOP_PWM_STATUS_ADDR = 8'h04;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam int unsigned STATUS_VALID_BIT      = 0;
  localparam int unsigned STATUS_OVERRUN_BIT    = 1;
  localparam int unsigned STATUS_STUCK_HIGH_BIT = 2;
  localparam int unsigned STATUS_STUCK_LOW_BIT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_edge_detect.sv
// Registers the PWM input once and flags the cycle in which the registered level rises.
module pwm_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s,
  output logic rise
);

  logic s_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s   <= pwm_in;
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of each complete PWM cycle on pwm_in and exposes the
// results, sticky status flags and an interrupt through the wen/ren register bus.
module pwm_capture
  import pwm_regs_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  input  logic              pwm_in,
  output logic              irq
);

  logic s;
  logic rise;

  pwm_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise)
  );

  cap_state_e          state_q;
  cap_state_e          state_d;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [STATUS_W-1:0] status_q;
  logic [STATUS_W-1:0] status_d;
  logic [STATUS_W-1:0] status_set;
  logic [STATUS_W-1:0] status_clr;
  logic [CNT_W-1:0]    high_q;
  logic [CNT_W-1:0]    period_q;
  logic [CNT_W-1:0]    high_cnt;
  logic [CNT_W-1:0]    period_cnt;
  logic [DATA_W-1:0]   rd_mux;

  logic enable;
  logic timeout;
  logic cnt_clr;
  logic cnt_load;
  logic cnt_inc;
  logic cnt_inc_high;
  logic latch;
  logic stuck_set;

  assign enable  = ctrl_q[CTRL_ENABLE_BIT];
  assign timeout = (period_cnt == CNT_W'(TIMEOUT));
  assign irq     = status_q[STATUS_VALID_BIT] & ctrl_q[CTRL_IRQ_EN_BIT];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; disable has priority, then a rising edge, then timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable) state_d = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        if (!enable)   state_d = ST_IDLE;
        else if (rise) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!enable)      state_d = ST_IDLE;
        else if (rise)    state_d = ST_MEASURE;
        else if (timeout) state_d = ST_WAIT_RISE;
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  // Counter and result control decoded from the current state
  always_comb begin
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    cnt_inc_high = 1'b0;
    latch        = 1'b0;
    stuck_set    = 1'b0;
    case (state_q)
      ST_WAIT_RISE: begin
        if (!enable)      cnt_clr = 1'b1;
        else if (rise)    cnt_load = 1'b1;
        else if (timeout) begin
          cnt_clr   = 1'b1;
          stuck_set = 1'b1;
        end else          cnt_inc = 1'b1;
      end
      ST_MEASURE: begin
        if (!enable) cnt_clr = 1'b1;
        else if (rise) begin
          latch    = 1'b1;
          cnt_load = 1'b1;
        end else if (timeout) begin
          cnt_clr   = 1'b1;
          stuck_set = 1'b1;
        end else begin
          cnt_inc      = 1'b1;
          cnt_inc_high = 1'b1;
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Rise cycle counts as the first cycle of the new period, hence the reload to 1
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (cnt_load) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else if (cnt_inc) begin
      period_cnt <= period_cnt + CNT_W'(1);
      if (cnt_inc_high) high_cnt <= high_cnt + CNT_W'(s);
    end
  end

  // Sticky status: hardware set wins over a same-cycle W1C
  always_comb begin
    status_set = '0;
    status_set[STATUS_VALID_BIT]      = latch;
    status_set[STATUS_OVERRUN_BIT]    = latch & status_q[STATUS_VALID_BIT];
    status_set[STATUS_STUCK_HIGH_BIT] = stuck_set & s;
    status_set[STATUS_STUCK_LOW_BIT]  = stuck_set & ~s;
    status_clr = (wen && addr == CAP_STATUS_ADDR) ? wdata[STATUS_W-1:0] : '0;
    status_d   = (status_q & ~status_clr) | status_set;
  end

  always_comb begin
    case (addr)
      CAP_CTRL_ADDR:   rd_mux = DATA_W'(ctrl_q);
      CAP_STATUS_ADDR: rd_mux = DATA_W'(status_q);
      CAP_HIGH_ADDR:   rd_mux = DATA_W'(high_q);
      CAP_PERIOD_ADDR: rd_mux = DATA_W'(period_q);
      default:         rd_mux = '0;
    endcase
  end

  // Register file; reads sample pre-write values
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      status_q <= '0;
      high_q   <= '0;
      period_q <= '0;
      rdata    <= '0;
    end else begin
      if (wen && addr == CAP_CTRL_ADDR) ctrl_q <= wdata[CTRL_W-1:0];
      status_q <= status_d;
      if (latch) begin
        high_q   <= high_cnt;
        period_q <= period_cnt;
      end
      if (ren) rdata <= rd_mux;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^wdata[DATA_W-1:STATUS_W];

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: read results are queued at the strobe and checked
// when rdata is loaded one cycle later.
module tb_pwm_capture;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_HIGH   = 8'h08;
  localparam logic [7:0] A_PERIOD = 8'h0C;
  localparam logic [7:0] A_NONE   = 8'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] rdata;
  logic        pwm_in = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  pwm_capture #(.CNT_W(16), .TIMEOUT(200)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .wen    (wen),
    .ren    (ren),
    .rdata  (rdata),
    .pwm_in (pwm_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, rdata, e);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    addr = a; ren = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    ren = 1'b0;
    pop_check();
  endtask

  task automatic pwm_high(input int n);
    pwm_in = 1'b1;
    ticks(n);
  endtask

  task automatic pwm_low(input int n);
    pwm_in = 1'b0;
    ticks(n);
  endtask

  initial begin
    // reset and idle
    ticks(2);
    reset = 1'b0;
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    bus_read(A_CTRL,   32'h0, "rst_ctrl");
    bus_read(A_STATUS, 32'h0, "rst_status");
    bus_read(A_HIGH,   32'h0, "rst_high");
    bus_read(A_PERIOD, 32'h0, "rst_period");
    for (int i = 0; i < 3; i++) begin
      pwm_high(5);
      pwm_low(5);
    end
    bus_read(A_STATUS, 32'h0, "idle_status");
    bus_read(A_HIGH,   32'h0, "idle_high");

    // basic capture: three 30/100 periods give two results
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < 3; i++) begin
      pwm_high(30);
      pwm_low(70);
    end
    bus_read(A_HIGH,   32'd30,  "cap_high");
    bus_read(A_PERIOD, 32'd100, "cap_period");
    bus_read(A_STATUS, 32'h3,   "cap_status");
    bus_write(A_STATUS, 32'h3);
    bus_read(A_STATUS, 32'h0, "cap_w1c");
    check("cap_irq_off", 32'(irq), 32'h0);

    // W1C of valid collides with the rise-cycle latch
    bus_write(A_CTRL, 32'h3);
    pwm_in = 1'b1;
    tick();
    addr = A_STATUS; wdata = 32'h1; wen = 1'b1;
    tick();
    wen = 1'b0;
    check("coll_irq", 32'(irq), 32'h1);
    bus_read(A_STATUS, 32'h1, "coll_status");
    bus_write(A_STATUS, 32'h1);
    check("clr_irq", 32'(irq), 32'h0);
    pwm_high(26);
    pwm_low(70);

    // stuck high: the opening rise latches the previous 30/100 period
    pwm_high(250);
    bus_read(A_STATUS, 32'h5,   "sh_status");
    bus_read(A_HIGH,   32'd30,  "sh_high");
    bus_read(A_PERIOD, 32'd100, "sh_period");
    bus_write(A_STATUS, 32'h5);
    pwm_low(250);
    bus_read(A_STATUS, 32'h8,   "sl_status");
    bus_read(A_HIGH,   32'd30,  "sl_high");
    bus_read(A_PERIOD, 32'd100, "sl_period");
    bus_write(A_STATUS, 32'hF);

    // disable 50 cycles into a period, then re-enable
    pwm_high(30);
    pwm_low(20);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_CTRL, 32'h1);
    pwm_low(58);
    pwm_high(30);
    pwm_low(70);
    pwm_high(2);
    bus_read(A_HIGH,   32'd30,  "dis_high");
    bus_read(A_PERIOD, 32'd100, "dis_period");
    bus_read(A_STATUS, 32'h1,   "dis_status");

    // bus edges
    bus_read(A_NONE, 32'h0, "unmapped");
    bus_write(A_HIGH, 32'hFFFF);
    bus_read(A_HIGH, 32'd30, "ro_high");
    addr = A_CTRL; wdata = 32'h3; wen = 1'b1; ren = 1'b1;
    exp_q.push_back(32'h1);
    tag_q.push_back("rw_old");
    tick();
    wen = 1'b0; ren = 1'b0;
    pop_check();
    bus_read(A_CTRL, 32'h3, "rw_new");

    // reset mid-period
    pwm_high(5);
    reset = 1'b1;
    pwm_in = 1'b0;
    tick();
    reset = 1'b0;
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    bus_read(A_CTRL,   32'h0, "mid_rst_ctrl");
    bus_read(A_STATUS, 32'h0, "mid_rst_status");
    bus_read(A_HIGH,   32'h0, "mid_rst_high");
    bus_read(A_PERIOD, 32'h0, "mid_rst_period");

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Bus-mapped PWM measurement block sitting directly downstream of `top_pwm`: it samples `pwm_out` and measures the high time and period of each complete PWM cycle in clock cycles. It exposes the results through the same 8-bit-address, 32-bit-data `wen`/`ren` register bus used by `top_pwm`. It is used for closed-loop checking of the generator in silicon and as a self-checking monitor in system benches.

## Interface
- `CNT_W`, 16: width of the high-time and period counters and result registers.
- `TIMEOUT`, 16'hFFFF: cycles without a rising edge before a stuck condition is declared; must be ≤ 2^CNT_W−1.
- `clk`  in  1  system clock, the same clock as `top_pwm`.
- `reset`  in  1  synchronous, active-high reset; one clock, synchronous to `clk`.
- `addr`  in  8  register byte address.
- `wdata`  in  32  write data.
- `wen`  in  1  write strobe, one cycle per access.
- `ren`  in  1  read strobe, one cycle per access.
- `rdata`  out  32  registered read data.
- `pwm_in`  in  1  PWM signal under measurement, synchronous to `clk`.
- `irq`  out  1  level output = STATUS.valid & CTRL.irq_en.

## Operation
- **Register map:**
  - 0x00 CTRL (RW): [0] enable, [1] irq_en.
  - 0x04 STATUS (W1C): [0] valid, [1] overrun, [2] stuck_high, [3] stuck_low.
  - 0x08 HIGH (RO): [CNT_W-1:0] high cycles of the last complete period.
  - 0x0C PERIOD (RO): [CNT_W-1:0] total cycles of the last complete period.
  - Unmapped reads return 0. Writes to RO or unmapped addresses are ignored. Upper bits read 0.
- **Input sampling:** `pwm_in` is registered into `s`; `s_d` is the previous `s`. `rise = s & ~s_d`.
- **FSM:**
  - IDLE: enable=0. Counters are held at 0.
  - IDLE → WAIT_RISE when enable=1.
  - WAIT_RISE → MEASURE on `rise`, loading period_cnt=1 and high_cnt=1.
  - Any state → IDLE when enable=0. Counters clear; result and STATUS registers keep their values.
- **MEASURE, each cycle:** period_cnt += 1; high_cnt += s.
- **MEASURE, cycle with `rise`:**
  - HIGH ← high_cnt and PERIOD ← period_cnt. These are the counts accumulated before this cycle.
  - Reload period_cnt=1, high_cnt=1.
  - Set valid. If valid was already 1, also set overrun.
- **Timeout:** when period_cnt reaches TIMEOUT in MEASURE or WAIT_RISE:
  - Set stuck_high if s=1, else stuck_low.
  - Clear counters and go to WAIT_RISE. HIGH and PERIOD are unchanged.
  - WAIT_RISE also counts cycles for timeout purposes.
- **Counter width:** counters never wrap because timeout fires first.
- **STATUS clearing:** writing 1 to a STATUS bit clears it. A hardware set in the same cycle as a W1C clear of that bit wins, so the bit stays 1.

## Timing
- **Reset values:** all registers 0; FSM in IDLE; `rdata`=0; `irq`=0; `s`, `s_d`=0.
- **Writes:** take effect at the posedge where `wen`=1. CTRL.enable=1 is visible to the FSM on the next cycle.
- **Reads:** `rdata` is loaded at the posedge where `ren`=1 and holds until the next read. Valid data is therefore available one cycle after the strobe. `wen` and `ren` together: the write is performed and the read returns the pre-write value.
- **Result latency:** the HIGH/PERIOD update and valid set happen 2 cycles after the `pwm_in` rising edge (input register, then rise-cycle register update).
- **Reset mid-measurement:** returns to the reset state on the next posedge and discards the partial period.

## Structure
- Shared package `pwm_regs_pkg` holds:
  - register addresses (0x00, 0x04, 0x08, 0x0C);
  - STATUS and CTRL bit indices;
  - FSM state encoding (IDLE, WAIT_RISE, MEASURE).
- The `top_pwm` CTRL/STATUS addresses move into the same package.
- One sub-module, `pwm_edge_detect`, contains the `s`/`s_d` registers and produces `rise` and the level `s`.
- The register file and FSM stay in `pwm_capture`.

## Test plan
- **Reset and idle:** reset high for 2 cycles. Read all four registers → 0. `irq`=0. With enable=0, toggling `pwm_in` leaves STATUS=0.
- **Basic capture:**
  - Enable.
  - Drive `pwm_in` at 30 high / 70 low for 3 periods.
  - Required: HIGH=30, PERIOD=100, STATUS=0x3 (valid and overrun, since no clear occurred between periods).
  - Write 0x3 to STATUS → reads 0.
- **Collision and irq:**
  - Set irq_en.
  - Issue a W1C of valid in the same cycle as a rise-cycle latch → valid stays 1 and `irq`=1.
  - Clear again with no collision → `irq`=0 the next cycle.
- **Stuck detection (TIMEOUT=200 in bench):**
  - `pwm_in` held 1 for 250 cycles → stuck_high=1, HIGH/PERIOD unchanged.
  - Repeat with `pwm_in` held 0 → stuck_low=1.
- **Disable and reset mid-period:**
  - Clear enable 50 cycles into a period, re-enable → the first valid result is a full period only (HIGH=30, PERIOD=100).
  - Assert reset mid-period → all registers 0.
- **Bus edges:**
  - Read 0x10 → 0.
  - Write 0xFFFF to HIGH → no change.
  - Simultaneous `wen`/`ren` to CTRL → `rdata` shows the old value, and a subsequent read shows the new value.
